spi_mem_ctrl: RTL and testbench

SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

---
 rtl/spi_mem_pkg.sv | 51 +++++
 rtl/spi_mem_ctrl.sv | 157 +++++++++++++++
 tb/tb_spi_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory controller: FSM state encoding,
// default opcodes, target select values and byte-sequencing helpers.
package spi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_ADDR_HI  = 3'd2,
        ST_ADDR_MID = 3'd3,
        ST_ADDR_LO  = 3'd4,
        ST_DATA     = 3'd5,
        ST_GAP      = 3'd6
    } state_t;

    localparam logic [7:0] DEF_CMD_READ  = 8'h03;
    localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

    localparam logic TGT_FLASH = 1'b0;
    localparam logic TGT_RAM   = 1'b1;

    // Byte state that follows the current one once its transfer completes.
    function automatic state_t next_byte_state(input state_t cur);
        state_t nxt;
        case (cur)
            ST_CMD:      nxt = ST_ADDR_HI;
            ST_ADDR_HI:  nxt = ST_ADDR_MID;
            ST_ADDR_MID: nxt = ST_ADDR_LO;
            ST_ADDR_LO:  nxt = ST_DATA;
            default:     nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

    // Byte shifted out in a given post-command state.
    function automatic logic [7:0] byte_for_state(
        input state_t      st,
        input logic [23:0] addr,
        input logic [7:0]  data_byte
    );
        logic [7:0] b;
        case (st)
            ST_ADDR_HI:  b = addr[23:16];
            ST_ADDR_MID: b = addr[15:8];
            ST_ADDR_LO:  b = addr[7:0];
            ST_DATA:     b = data_byte;
            default:     b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_mem_ctrl.sv
// Byte-level SPI memory controller: turns single-byte read/write requests into
// opcode + 24-bit address + data sequences for a flash or RAM device.
module spi_mem_ctrl
    import spi_mem_pkg::*;
#(
    parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_target,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic [7:0]  spi_data_tx,
    input  logic [7:0]  spi_data_rx,
    output logic        spi_txn_start,
    input  logic        spi_txn_done,
    output logic        spi_flash_ce_n,
    output logic        spi_ram_ce_n
);

    state_t      state_q, state_d;
    logic [23:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        write_q, write_d;
    logic        target_q, target_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [7:0]  resp_rdata_q, resp_rdata_d;
    logic [7:0]  spi_data_tx_q, spi_data_tx_d;
    logic        spi_txn_start_q, spi_txn_start_d;
    logic        flash_ce_n_q, flash_ce_n_d;
    logic        ram_ce_n_q, ram_ce_n_d;

    // Next-state, request capture and registered-output computation.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        write_d         = write_q;
        target_d        = target_q;
        resp_valid_d    = 1'b0;
        resp_err_d      = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        spi_data_tx_d   = spi_data_tx_q;
        spi_txn_start_d = 1'b0;
        flash_ce_n_d    = flash_ce_n_q;
        ram_ce_n_d      = ram_ce_n_q;

        case (state_q)
            ST_IDLE: begin
                flash_ce_n_d = 1'b1;
                ram_ce_n_d   = 1'b1;
                if (req_valid && req_ready_q) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    write_d  = req_write;
                    target_d = req_target;
                    // Flash is treated as read-only: writes bounce without touching the bus.
                    if (req_write && (req_target == TGT_FLASH)) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d         = ST_CMD;
                        spi_txn_start_d = 1'b1;
                        spi_data_tx_d   = req_write ? CMD_WRITE : CMD_READ;
                        flash_ce_n_d    = (req_target != TGT_FLASH);
                        ram_ce_n_d      = (req_target != TGT_RAM);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD, ST_ADDR_HI, ST_ADDR_MID, ST_ADDR_LO: begin
                if (spi_txn_done) begin
                    state_d         = next_byte_state(state_q);
                    spi_txn_start_d = 1'b1;
                    spi_data_tx_d   = byte_for_state(next_byte_state(state_q), addr_q,
                                                     write_q ? wdata_q : 8'h00);
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                if (spi_txn_done) begin
                    state_d      = ST_GAP;
                    flash_ce_n_d = 1'b1;
                    ram_ce_n_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? 8'h00 : spi_data_rx;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                flash_ce_n_d = 1'b1;
                ram_ce_n_d   = 1'b1;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            addr_q          <= 24'h000000;
            wdata_q         <= 8'h00;
            write_q         <= 1'b0;
            target_q        <= 1'b0;
            req_ready_q     <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_err_q      <= 1'b0;
            resp_rdata_q    <= 8'h00;
            spi_data_tx_q   <= 8'h00;
            spi_txn_start_q <= 1'b0;
            flash_ce_n_q    <= 1'b1;
            ram_ce_n_q      <= 1'b1;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            write_q         <= write_d;
            target_q        <= target_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_err_q      <= resp_err_d;
            resp_rdata_q    <= resp_rdata_d;
            spi_data_tx_q   <= spi_data_tx_d;
            spi_txn_start_q <= spi_txn_start_d;
            flash_ce_n_q    <= flash_ce_n_d;
            ram_ce_n_q      <= ram_ce_n_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign spi_data_tx    = spi_data_tx_q;
    assign spi_txn_start  = spi_txn_start_q;
    assign spi_flash_ce_n = flash_ce_n_q;
    assign spi_ram_ce_n   = ram_ce_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Scoreboard bench for spi_mem_ctrl: a byte-level SPI master model checks each
// shifted byte, and a response monitor checks completions against a queue.
module tb_spi_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_target;
    logic [23:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_err;
    logic [7:0]  spi_data_tx;
    logic [7:0]  spi_data_rx;
    logic        spi_txn_start;
    logic        spi_txn_done;
    logic        spi_flash_ce_n;
    logic        spi_ram_ce_n;

    spi_mem_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_target     (req_target),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .spi_data_tx    (spi_data_tx),
        .spi_data_rx    (spi_data_rx),
        .spi_txn_start  (spi_txn_start),
        .spi_txn_done   (spi_txn_done),
        .spi_flash_ce_n (spi_flash_ce_n),
        .spi_ram_ce_n   (spi_ram_ce_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic       target;
        logic [7:0] rx;
        int         delay;
    } byte_exp_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } resp_exp_t;

    byte_exp_t  exp_tx_q[$];
    resp_exp_t  exp_resp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         start_cnt   = 0;
    int         byte_idx    = 0;
    int         stray_req   = 0;
    logic [7:0] last_rdata  = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_byte(input logic [7:0] tx, input logic tgt, input logic [7:0] rx,
                             input int delay);
        byte_exp_t e;
        e.tx = tx; e.target = tgt; e.rx = rx; e.delay = delay;
        exp_tx_q.push_back(e);
    endtask

    // SPI master model: checks each started byte, holds it for 'delay' cycles, then ends it.
    initial begin : spi_model
        byte_exp_t  cur;
        bit         busy;
        bit         ce_gap_seen;
        int         wait_cnt;
        int         stray_seen;
        logic [7:0] held_tx;
        busy = 1'b0; ce_gap_seen = 1'b0; wait_cnt = 0; stray_seen = 0; held_tx = 8'h00;
        cur.tx = 8'h00; cur.target = 1'b0; cur.rx = 8'h00; cur.delay = 0;
        spi_txn_done = 1'b0;
        spi_data_rx  = 8'h00;
        forever begin
            @(negedge clk);
            spi_txn_done = 1'b0;
            if (rst) begin
                busy = 1'b0;
                byte_idx = 0;
                stray_seen = stray_req;
            end else begin
                if (spi_flash_ce_n && spi_ram_ce_n) ce_gap_seen = 1'b1;
                if (spi_txn_start) begin
                    start_cnt++;
                    check("start_while_busy", busy, 1'b0);
                    check("tx_queue_nonempty", exp_tx_q.size() != 0, 1'b1);
                    if (exp_tx_q.size() != 0) begin
                        cur = exp_tx_q.pop_front();
                    end else begin
                        cur.tx = spi_data_tx; cur.target = spi_flash_ce_n; cur.rx = 8'h00; cur.delay = 0;
                    end
                    check("tx_byte", spi_data_tx, cur.tx);
                    if (byte_idx == 0) begin
                        check("ce_gap_before_txn", ce_gap_seen, 1'b1);
                        ce_gap_seen = 1'b0;
                    end
                    byte_idx = (byte_idx == 4) ? 0 : byte_idx + 1;
                    busy     = 1'b1;
                    wait_cnt = cur.delay;
                    held_tx  = spi_data_tx;
                end
                if (busy) begin
                    check("tx_stable", spi_data_tx, held_tx);
                    check("flash_ce_n_active", spi_flash_ce_n, cur.target == 1'b1);
                    check("ram_ce_n_active", spi_ram_ce_n, cur.target == 1'b0);
                    check("req_ready_busy", req_ready, 1'b0);
                    if (wait_cnt == 0) begin
                        spi_txn_done = 1'b1;
                        spi_data_rx  = cur.rx;
                        busy         = 1'b0;
                    end else begin
                        wait_cnt--;
                    end
                end else if (stray_seen != stray_req) begin
                    stray_seen   = stray_req;
                    spi_txn_done = 1'b1;
                    spi_data_rx  = 8'hEE;
                end
            end
        end
    end

    // Response monitor: every completion pulse must match the oldest expected response.
    initial begin : resp_monitor
        resp_exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                check("resp_queue_nonempty", exp_resp_q.size() != 0, 1'b1);
                if (exp_resp_q.size() != 0) begin
                    e = exp_resp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", resp_err, e.err);
                    check("ce_high_on_resp", {spi_flash_ce_n, spi_ram_ce_n}, 2'b11);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic wr, input logic tgt, input logic [23:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rx, input int delay,
                         input bit hold_valid);
        bit accepted;
        resp_exp_t r;
        if (wr && !tgt) begin
            r.rdata = last_rdata; r.err = 1'b1;
        end else begin
            push_byte(wr ? 8'h02 : 8'h03, tgt, rx, delay);
            push_byte(addr[23:16], tgt, rx, delay);
            push_byte(addr[15:8], tgt, rx, delay);
            push_byte(addr[7:0], tgt, rx, delay);
            push_byte(wr ? wdata : 8'h00, tgt, rx, delay);
            last_rdata = wr ? 8'h00 : rx;
            r.rdata = last_rdata; r.err = 1'b0;
        end
        exp_resp_q.push_back(r);
        req_valid = 1'b1; req_write = wr; req_target = tgt; req_addr = addr; req_wdata = wdata;
        accepted = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("req_accepted", accepted, 1'b1);
        @(posedge clk);
        #1;
        if (!hold_valid) begin
            req_valid = 1'b0;
            req_addr = ~addr; req_wdata = ~wdata; req_write = ~wr; req_target = ~tgt;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_tx_q.size() != 0 || exp_resp_q.size() != 0 || !req_ready) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_within_budget", n < 1000, 1'b1);
    endtask

    initial begin : stimulus
        int s0;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_target = 1'b0;
        req_addr = 24'h000000; req_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_flash_ce_n", spi_flash_ce_n, 1'b1);
        check("rst_ram_ce_n", spi_ram_ce_n, 1'b1);
        check("rst_start", spi_txn_start, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_rdata", resp_rdata, 8'h00);
        check("rst_tx", spi_data_tx, 8'h00);
        check("rst_req_ready", req_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        s0 = start_cnt;
        issue(1'b0, 1'b1, 24'h012345, 8'h00, 8'hA5, 0, 1'b0);
        wait_idle();
        check("starts_ram_read", start_cnt - s0, 5);

        s0 = start_cnt;
        issue(1'b1, 1'b1, 24'h000010, 8'h5A, 8'h77, 1, 1'b0);
        wait_idle();
        check("starts_ram_write", start_cnt - s0, 5);

        s0 = start_cnt;
        issue(1'b1, 1'b0, 24'h000200, 8'hC3, 8'h00, 0, 1'b0);
        check("reject_ce_n", {spi_flash_ce_n, spi_ram_ce_n}, 2'b11);
        repeat (3) @(negedge clk);
        wait_idle();
        check("starts_flash_reject", start_cnt - s0, 0);

        s0 = start_cnt;
        issue(1'b0, 1'b0, 24'hFFFFFF, 8'h00, 8'h3C, 20, 1'b0);
        wait_idle();
        check("starts_flash_slow_read", start_cnt - s0, 5);

        s0 = start_cnt;
        issue(1'b0, 1'b1, 24'h000100, 8'h00, 8'h11, 2, 1'b1);
        issue(1'b0, 1'b1, 24'h0ABCDE, 8'h00, 8'h22, 0, 1'b0);
        wait_idle();
        check("starts_back_to_back", start_cnt - s0, 10);

        // Abort a read while its ADDR_MID byte is in flight.
        issue(1'b0, 1'b1, 24'h123456, 8'h00, 8'h99, 4, 1'b0);
        n = 0;
        while (byte_idx != 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_addr_mid", byte_idx, 3);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ce_n", {spi_flash_ce_n, spi_ram_ce_n}, 2'b11);
        check("abort_start", spi_txn_start, 1'b0);
        check("abort_resp_valid", resp_valid, 1'b0);
        check("abort_req_ready", req_ready, 1'b0);
        check("abort_tx", spi_data_tx, 8'h00);
        check("abort_bytes_left", exp_tx_q.size(), 2);
        check("abort_resp_left", exp_resp_q.size(), 1);
        exp_tx_q.delete();
        exp_resp_q.delete();
        last_rdata = 8'h00;
        rst = 1'b0;
        @(negedge clk);
        s0 = start_cnt;
        stray_req++;
        repeat (6) @(negedge clk);
        check("stray_done_no_start", start_cnt - s0, 0);
        check("post_abort_rdata", resp_rdata, 8'h00);

        s0 = start_cnt;
        issue(1'b0, 1'b1, 24'hABCDEF, 8'h00, 8'h5C, 0, 1'b0);
        wait_idle();
        check("starts_after_abort", start_cnt - s0, 5);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
